// File: rtl/plan_logit_if.sv
// Streaming bus for the PLAN inverse: probability in, pre-activation out.
interface plan_logit_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic         sat;

  // Block side: consumes y, produces x/sat.
  modport slave (
    input  in_valid, y, out_ready,
    output in_ready, out_valid, x, sat
  );

  // Driver/consumer side.
  modport master (
    output in_valid, y, out_ready,
    input  in_ready, out_valid, x, sat
  );
endinterface

// File: rtl/plan_logit.sv
// Inverse PLAN sigmoid: unsigned Q4.12 probability -> signed Q4.12 pre-activation.
// Three-stage pipeline (fold, segment select, scale/sign) with a single
// global advance signal, so the whole pipe either moves or holds.
module plan_logit #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int XSAT  = 20480
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  plan_logit_if.slave     bus
);

  localparam logic [W-1:0] ONE   = W'(1 << FRAC);        // 1.0
  localparam logic [W-1:0] HALF  = W'(1 << (FRAC - 1));  // 0.5
  // Segment limits and offsets on the folded probability m in [0.5, 1.0].
  localparam logic [W-1:0] SEG2_LO = W'(3072);
  localparam logic [W-1:0] SEG3_LO = W'(3776);
  localparam logic [W-1:0] OFF1    = W'(2048);
  localparam logic [W-1:0] OFF2    = W'(2560);
  localparam logic [W-1:0] OFF3    = W'(3456);
  localparam logic [W:0]   XSAT_W  = (W+1)'(XSAT);

  // Stage 1 registers
  logic         v1_q, v1_d;
  logic         neg1_q, neg1_d;
  logic         isat1_q, isat1_d;
  logic [W-1:0] m1_q, m1_d;
  // Stage 2 registers
  logic         v2_q, v2_d;
  logic         neg2_q, neg2_d;
  logic         isat2_q, isat2_d;
  logic         ssat2_q, ssat2_d;
  logic [W-1:0] d2_q, d2_d;
  logic [2:0]   sh2_q, sh2_d;
  // Stage 3 / output registers
  logic         v3_q, v3_d;
  logic [W-1:0] x_q, x_d;
  logic         sat_q, sat_d;

  logic         adv;
  logic [W-1:0] yc;
  logic [W:0]   mag;

  assign adv           = en & (~v3_q | bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.x         = x_q;
  assign bus.sat       = sat_q;

  // Next-state for all three stages; everything holds unless the pipe advances.
  always_comb begin
    v1_d    = v1_q;
    neg1_d  = neg1_q;
    isat1_d = isat1_q;
    m1_d    = m1_q;
    v2_d    = v2_q;
    neg2_d  = neg2_q;
    isat2_d = isat2_q;
    ssat2_d = ssat2_q;
    d2_d    = d2_q;
    sh2_d   = sh2_q;
    v3_d    = v3_q;
    x_d     = x_q;
    sat_d   = sat_q;
    yc      = (bus.y > ONE) ? ONE : bus.y;
    mag     = ssat2_q ? XSAT_W : ({1'b0, d2_q} << sh2_q);

    if (adv) begin
      // Stage 1: clamp, then fold the lower half onto [0.5, 1.0] by symmetry.
      v1_d    = bus.in_valid;
      isat1_d = (bus.y > ONE);
      neg1_d  = (yc < HALF);
      m1_d    = (yc < HALF) ? (ONE - yc) : yc;

      // Stage 2: pick the linear segment; m == 1.0 has no finite inverse.
      v2_d    = v1_q;
      neg2_d  = neg1_q;
      isat2_d = isat1_q;
      ssat2_d = 1'b0;
      if (m1_q >= ONE) begin
        ssat2_d = 1'b1;
        d2_d    = '0;
        sh2_d   = 3'd0;
      end else if (m1_q < SEG2_LO) begin
        d2_d    = m1_q - OFF1;
        sh2_d   = 3'd2;
      end else if (m1_q < SEG3_LO) begin
        d2_d    = m1_q - OFF2;
        sh2_d   = 3'd3;
      end else begin
        d2_d    = m1_q - OFF3;
        sh2_d   = 3'd5;
      end

      // Stage 3: scale and restore sign; only real data updates the output.
      v3_d = v2_q;
      if (v2_q) begin
        x_d   = W'(neg2_q ? ((W+1)'(0) - mag) : mag);
        sat_d = isat2_q | ssat2_q;
      end
    end
  end

  // Pipeline registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      neg1_q  <= 1'b0;
      isat1_q <= 1'b0;
      m1_q    <= '0;
      v2_q    <= 1'b0;
      neg2_q  <= 1'b0;
      isat2_q <= 1'b0;
      ssat2_q <= 1'b0;
      d2_q    <= '0;
      sh2_q   <= 3'd0;
      v3_q    <= 1'b0;
      x_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      neg1_q  <= neg1_d;
      isat1_q <= isat1_d;
      m1_q    <= m1_d;
      v2_q    <= v2_d;
      neg2_q  <= neg2_d;
      isat2_q <= isat2_d;
      ssat2_q <= ssat2_d;
      d2_q    <= d2_d;
      sh2_q   <= sh2_d;
      v3_q    <= v3_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
    end
  end

endmodule
